// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM types, oversample ratio and baud divisor helper
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
   endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider issuing a one-cycle 16x oversample tick
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   if (DIV < 2) begin : g_div_check
      $error("uart_baud_gen: CLK_HZ/(16*BAUD) must round to at least 2");
   end
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == CW'(DIV - 1);
   // count 0..DIV-1 and wrap at terminal count
   always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
   // divider register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 LSB-first UART receiver and transmitter, line idle high
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rxData,
   output logic       rxReady,
   output logic       rxFrameErr,
   input  logic [7:0] txData,
   input  logic       txStart,
   output logic       txBusy
);
   localparam int BIT_CYC = OVERSAMPLE * calc_div(CLK_HZ, BAUD);
   localparam int CW      = $clog2(BIT_CYC);
   logic            tick, rxs, bit_end;
   logic [1:0]      sync_q, sync_d;
   rx_state_t       rx_state_q, rx_state_d;
   logic [3:0]      sc_q, sc_d;
   logic [2:0]      bc_q, bc_d;
   logic [7:0]      rsh_q, rsh_d, rx_data_q, rx_data_d;
   logic            rx_ready_q, rx_ready_d, rx_err_q, rx_err_d;
   tx_state_t       tx_state_q, tx_state_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [2:0]      tbc_q, tbc_d;
   logic [7:0]      tsh_q, tsh_d;
   logic            tx_q, tx_d;
   uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );
   assign rxs        = sync_q[1];
   assign rxData     = rx_data_q;
   assign rxReady    = rx_ready_q;
   assign rxFrameErr = rx_err_q;
   assign tx         = tx_q;
   assign txBusy     = tx_state_q != TX_IDLE;
   assign bit_end    = cyc_q == CW'(BIT_CYC - 1);
   // RX: synchronise the pin, then step the oversampling FSM on each tick
   always_comb begin
      sync_d     = {sync_q[0], rx};
      rx_state_d = rx_state_q;
      sc_d       = sc_q;
      bc_d       = bc_q;
      rsh_d      = rsh_q;
      rx_data_d  = rx_data_q;
      rx_ready_d = 1'b0;
      rx_err_d   = 1'b0;
      if (tick) begin
         case (rx_state_q)
            RX_IDLE: if (!rxs) begin
               rx_state_d = RX_START;
               sc_d       = '0;
            end
            RX_START: if (sc_q == 4'd7) begin
               if (rxs) rx_state_d = RX_IDLE;
               else rx_state_d = RX_DATA;
               sc_d = '0;
               bc_d = '0;
            end else sc_d = sc_q + 4'd1;
            RX_DATA: begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  rsh_d = {rxs, rsh_q[7:1]};
                  bc_d  = bc_q + 3'd1;
                  if (bc_q == 3'd7) rx_state_d = RX_STOP;
               end
            end
            default: begin
               sc_d = sc_q + 4'd1;
               if (sc_q == 4'd15) begin
                  rx_state_d = RX_IDLE;
                  rx_ready_d = rxs;
                  rx_err_d   = !rxs;
                  rx_data_d  = rxs ? rsh_q : rx_data_q;
               end
            end
         endcase
      end
   end
   // TX: exact BIT_CYC-cycle bits from a free cycle counter, LSB first
   always_comb begin
      tx_state_d = tx_state_q;
      tbc_d      = tbc_q;
      tsh_d      = tsh_q;
      tx_d       = tx_q;
      cyc_d      = (tx_state_q == TX_IDLE || bit_end) ? '0 : cyc_q + 1'b1;
      case (tx_state_q)
         TX_IDLE: if (txStart) begin
            tx_state_d = TX_START;
            tsh_d      = txData;
            tx_d       = 1'b0;
         end
         TX_START: if (bit_end) begin
            tx_state_d = TX_DATA;
            tbc_d      = '0;
            tx_d       = tsh_q[0];
         end
         TX_DATA: if (bit_end) begin
            tsh_d = tsh_q >> 1;
            tbc_d = tbc_q + 3'd1;
            tx_d  = tbc_q == 3'd7 ? 1'b1 : tsh_q[1];
            if (tbc_q == 3'd7) tx_state_d = TX_STOP;
         end
         default: if (bit_end) tx_state_d = TX_IDLE;
      endcase
   end
   // RX registers; reset drops any partial byte and parks the line high
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= 2'b11;
         rx_state_q <= RX_IDLE;
         sc_q       <= '0;
         bc_q       <= '0;
         rsh_q      <= '0;
         rx_data_q  <= '0;
         rx_ready_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rx_state_q <= rx_state_d;
         sc_q       <= sc_d;
         bc_q       <= bc_d;
         rsh_q      <= rsh_d;
         rx_data_q  <= rx_data_d;
         rx_ready_q <= rx_ready_d;
         rx_err_q   <= rx_err_d;
      end
   end
   // TX registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= TX_IDLE;
         cyc_q      <= '0;
         tbc_q      <= '0;
         tsh_q      <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         cyc_q      <= cyc_d;
         tbc_q      <= tbc_d;
         tsh_q      <= tsh_d;
         tx_q       <= tx_d;
      end
   end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed checks of loopback, glitch, framing, back-to-back, busy and reset
module tb_uart_transceiver;
   import uart_pkg::*;
   logic       clk = 1'b0, reset = 1'b1, rx_drv = 1'b1, loop = 1'b0, txStart = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       rx_w, tx, rxReady, rxFrameErr, txBusy;
   logic [7:0] rxData;
   int         checks = 0, errors = 0;
   int         rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
   logic [7:0] rx_log [64];
   assign rx_w = loop ? tx : rx_drv;
   always #5 clk = ~clk;
   uart_transceiver dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx_w),
      .tx        (tx),
      .rxData    (rxData),
      .rxReady   (rxReady),
      .rxFrameErr(rxFrameErr),
      .txData    (txData),
      .txStart   (txStart),
      .txBusy    (txBusy)
   );
   always @(negedge clk) begin
      if (rxReady) begin
         rx_log[rdy_cnt[5:0]] <= rxData;
         rdy_cnt <= rdy_cnt + 1;
      end
      if (rxFrameErr) err_cnt <= err_cnt + 1;
      if (rxReady && rxFrameErr) both_cnt <= both_cnt + 1;
   end
   initial begin
      #900000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input int bc, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_drv = f[k];
         repeat (bc) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask
   task automatic tx_frame(input logic [7:0] b, input int late_n, input logic [7:0] late_b,
                           output logic [9:0] wave, output int fall);
      @(negedge clk);
      txData  = b;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      txData  = 8'h00;
      wave    = '0;
      fall    = -1;
      for (int n = 0; n < 4400 && fall < 0; n++) begin
         if (n % 432 == 216 && n < 4320) wave[n / 432] = tx;
         if (!txBusy) fall = n;
         if (n == late_n) begin
            txData  = late_b;
            txStart = 1'b1;
         end else txStart = 1'b0;
         @(negedge clk);
      end
      txStart = 1'b0;
   endtask
   initial begin
      logic [9:0] wave;
      int fall, r0, e0;
      logic [9:0] f;
      repeat (4) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", txBusy, 1'b0);
      chk("rst_ready", rxReady, 1'b0);
      chk("rst_ferr", rxFrameErr, 1'b0);
      chk("rst_data", rxData, 8'h00);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      loop = 1'b1;
      r0 = rdy_cnt; e0 = err_cnt;
      tx_frame(8'hA5, -1, 8'h00, wave, fall);
      chk("a5_wave", wave, 10'b1101001010);
      chk("a5_fall", fall, 4320);
      repeat (50) @(negedge clk);
      chk("a5_rdy", rdy_cnt - r0, 1);
      chk("a5_data", rx_log[r0[5:0]], 8'hA5);
      chk("a5_ferr", err_cnt - e0, 0);
      loop = 1'b0;
      repeat (500) @(negedge clk);
      r0 = rdy_cnt; e0 = err_cnt;
      rx_drv = 1'b0;
      repeat (81) @(negedge clk);
      rx_drv = 1'b1;
      repeat (600) @(negedge clk);
      chk("glitch_rdy", rdy_cnt - r0, 0);
      chk("glitch_ferr", err_cnt - e0, 0);
      chk("glitch_state", dut.rx_state_q, RX_IDLE);
      r0 = rdy_cnt; e0 = err_cnt;
      send_byte(8'h11, 432, 1'b1);
      repeat (10) @(negedge clk);
      chk("good11_rdy", rdy_cnt - r0, 1);
      chk("good11_data", rx_log[r0[5:0]], 8'h11);
      r0 = rdy_cnt;
      send_byte(8'h3C, 432, 1'b0);
      repeat (600) @(negedge clk);
      chk("ferr_cnt", err_cnt - e0, 1);
      chk("ferr_rdy", rdy_cnt - r0, 0);
      chk("ferr_hold", rxData, 8'h11);
      r0 = rdy_cnt; e0 = err_cnt;
      send_byte(8'h00, 419, 1'b1);
      send_byte(8'hFF, 419, 1'b1);
      send_byte(8'h0A, 419, 1'b1);
      repeat (600) @(negedge clk);
      chk("b2b_cnt", rdy_cnt - r0, 3);
      chk("b2b_d0", rx_log[r0[5:0]], 8'h00);
      chk("b2b_d1", rx_log[6'(r0 + 1)], 8'hFF);
      chk("b2b_d2", rx_log[6'(r0 + 2)], 8'h0A);
      chk("b2b_ferr", err_cnt - e0, 0);
      tx_frame(8'h81, 1000, 8'h55, wave, fall);
      chk("busy_wave", wave, 10'b1100000010);
      chk("busy_fall", fall, 4320);
      repeat (10) @(negedge clk);
      chk("busy_idle", txBusy, 1'b0);
      tx_frame(8'h55, -1, 8'h00, wave, fall);
      chk("w55_wave", wave, 10'b1010101010);
      chk("w55_fall", fall, 4320);
      repeat (10) @(negedge clk);
      r0 = rdy_cnt; e0 = err_cnt;
      txData  = 8'hC3;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      repeat (3 * 432 + 216) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("txrst_tx", tx, 1'b1);
      chk("txrst_busy", txBusy, 1'b0);
      chk("txrst_rdy", rxReady, 1'b0);
      chk("txrst_ferr", rxFrameErr, 1'b0);
      repeat (20) @(negedge clk);
      chk("txrst_stay", txBusy, 1'b0);
      f = {1'b1, 8'hC3, 1'b0};
      for (int k = 0; k < 7; k++) begin
         rx_drv = f[k];
         repeat (k == 6 ? 216 : 432) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      rx_drv = 1'b1;
      repeat (1000) @(negedge clk);
      chk("rxrst_rdy", rdy_cnt - r0, 0);
      chk("rxrst_ferr", err_cnt - e0, 0);
      loop = 1'b1;
      tx_frame(8'hC3, -1, 8'h00, wave, fall);
      chk("c3_wave", wave, 10'b1110000110);
      chk("c3_fall", fall, 4320);
      repeat (50) @(negedge clk);
      chk("c3_rdy", rdy_cnt - r0, 1);
      chk("c3_data", rxData, 8'hC3);
      chk("c3_ferr", err_cnt - e0, 0);
      chk("never_both", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
